// File: rtl/logic_unit_pkg.sv
// Shared types for the bitwise logic unit: operation encoding and the
// per-result status flags stored alongside data when LOGIC_UNIT_FLAGS_EN
// is defined.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    LOP_NOT  = 3'b000,
    LOP_AND  = 3'b001,
    LOP_OR   = 3'b010,
    LOP_XOR  = 3'b011,
    LOP_NAND = 3'b100,
    LOP_NOR  = 3'b101,
    LOP_XNOR = 3'b110,
    LOP_PASS = 3'b111
  } logic_op_e;

  typedef struct packed {
    logic zero;
    logic parity;
  } logic_flags_t;

endpackage

// File: rtl/logic_unit_op_core.sv
// Combinational bitwise operation core. Result is forced to zero when
// enable is low. Flag outputs exist only with LOGIC_UNIT_FLAGS_EN.
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic             enable,
  input  logic [WIDTH-1:0] reg_s1,
  input  logic [WIDTH-1:0] reg_s2,
`ifdef LOGIC_UNIT_FLAGS_EN
  output logic_flags_t     flags,
`endif
  output logic [WIDTH-1:0] result
);

  logic_op_e op_e;

  assign op_e = logic_op_e'(op);

  // Select the bitwise function, gated by enable
  always_comb begin
    result = '0;
    if (enable) begin
      case (op_e)
        LOP_NOT:  result = ~reg_s1;
        LOP_AND:  result = reg_s1 & reg_s2;
        LOP_OR:   result = reg_s1 | reg_s2;
        LOP_XOR:  result = reg_s1 ^ reg_s2;
        LOP_NAND: result = ~(reg_s1 & reg_s2);
        LOP_NOR:  result = ~(reg_s1 | reg_s2);
        LOP_XNOR: result = ~(reg_s1 ^ reg_s2);
        LOP_PASS: result = reg_s1;
      endcase
    end
  end

`ifdef LOGIC_UNIT_FLAGS_EN
  // Status flags derived from the final (possibly gated) result
  always_comb begin
    flags        = '0;
    flags.zero   = (result == '0);
    flags.parity = ^result;
  end
`endif

endmodule

// File: rtl/logic_unit.sv
// Handshaked bitwise logic unit: one registered output stage (OUT) backed
// by a skid register (SKID) so in_ready depends only on registered state.
// Optional flags (flag_zero, flag_parity) with LOGIC_UNIT_FLAGS_EN.
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             enable,
  input  logic [WIDTH-1:0] reg_s1,
  input  logic [WIDTH-1:0] reg_s2,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef LOGIC_UNIT_FLAGS_EN
  output logic             flag_zero,
  output logic             flag_parity,
`endif
  output logic [WIDTH-1:0] reg_d
);

  // Occupancy encoded directly as {out_v, skid_v}
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic             out_v;
  logic             skid_v;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] skid_data;
  logic [WIDTH-1:0] result;
  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             accept;
  logic             emit;
  logic             load_out;
  logic             load_skid;
  logic             move_skid;

`ifdef LOGIC_UNIT_FLAGS_EN
  logic_flags_t     result_flags;
  logic_flags_t     out_flags;
  logic_flags_t     skid_flags;
`endif

  logic_op_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op     (op),
    .enable (enable),
    .reg_s1 (reg_s1),
    .reg_s2 (reg_s2),
`ifdef LOGIC_UNIT_FLAGS_EN
    .flags  (result_flags),
`endif
    .result (result)
  );

  assign state     = {out_v, skid_v};
  assign in_ready  = !skid_v;
  assign accept    = in_valid && in_ready;
  assign emit      = out_v && out_ready;
  assign out_valid = out_v;
  assign reg_d     = out_data;

`ifdef LOGIC_UNIT_FLAGS_EN
  assign flag_zero   = out_flags.zero;
  assign flag_parity = out_flags.parity;
`endif

  // Next occupancy and register load strobes
  always_comb begin
    state_next = state;
    load_out   = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_next = ST_ONE;
          load_out   = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && emit) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_next = ST_FULL;
          load_skid  = 1'b1;
        end else if (emit) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (emit) begin
          state_next = ST_ONE;
          move_skid  = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // Valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      out_v  <= state_next[1];
      skid_v <= state_next[0];
    end
  end

  // Data registers; SKID is cleared once its contents move to OUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      if (load_out) begin
        out_data <= result;
      end else if (move_skid) begin
        out_data <= skid_data;
      end
      if (load_skid) begin
        skid_data <= result;
      end else if (move_skid) begin
        skid_data <= '0;
      end
    end
  end

`ifdef LOGIC_UNIT_FLAGS_EN
  // Flag registers follow their data word through OUT/SKID
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_flags  <= '0;
      skid_flags <= '0;
    end else begin
      if (load_out) begin
        out_flags <= result_flags;
      end else if (move_skid) begin
        out_flags <= skid_flags;
      end
      if (load_skid) begin
        skid_flags <= result_flags;
      end else if (move_skid) begin
        skid_flags <= '0;
      end
    end
  end
`endif

  // SKID is never occupied while OUT is empty
  ap_no_orphan_skid: assert property (@(posedge clk) disable iff (rst)
    !(skid_v && !out_v));

  // A stalled result stays put until taken
  ap_hold_on_stall: assert property (@(posedge clk) disable iff (rst)
    (out_v && !out_ready) |=> (out_v && $stable(out_data)));

endmodule

// File: tb/tb_logic_unit.sv
// Self-checking bench for logic_unit (WIDTH=32): directed cases plus a
// scoreboard that tracks every accepted result through to its emit.
module tb_logic_unit;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic         enable;
  logic [W-1:0] reg_s1;
  logic [W-1:0] reg_s2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] reg_d;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic         flag_zero;
  logic         flag_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  bit rand_done;

  logic_unit #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .enable     (enable),
    .reg_s1     (reg_s1),
    .reg_s2     (reg_s2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef LOGIC_UNIT_FLAGS_EN
    .flag_zero  (flag_zero),
    .flag_parity(flag_parity),
`endif
    .reg_d      (reg_d)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic en);
    logic [W-1:0] r;
    case (o)
      3'd0: r = ~a;
      3'd1: r = a & b;
      3'd2: r = a | b;
      3'd3: r = a ^ b;
      3'd4: r = ~(a & b);
      3'd5: r = ~(a | b);
      3'd6: r = ~(a ^ b);
      default: r = a;
    endcase
    return en ? r : '0;
  endfunction

  // Scoreboard: compare occupancy and head result, then advance on handshakes
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    end else begin
      check_eq("sb_out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
      check_eq("sb_in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < 2});
      if (out_valid && exp_q.size() != 0) begin
        check_eq("sb_reg_d", {32'd0, reg_d}, {32'd0, exp_q[0]});
`ifdef LOGIC_UNIT_FLAGS_EN
        check_eq("sb_flag_zero", {63'd0, flag_zero}, {63'd0, exp_q[0] == '0});
        check_eq("sb_flag_parity", {63'd0, flag_parity}, {63'd0, ^exp_q[0]});
`endif
      end
      if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) exp_q.push_back(ref_op(op, reg_s1, reg_s2, enable));
    end
  end

  // Present one operation and hold it until accepted (called at posedge+1)
  task automatic drive(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic en);
    int unsigned n;
    op = o; reg_s1 = a; reg_s2 = b; enable = en; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check_eq("accept_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; op = '0; enable = 1'b1;
    reg_s1 = '0; reg_s2 = '0; out_ready = 1'b1; rand_done = 1'b0;
    #1;
    check_eq("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("reset_reg_d", {32'd0, reg_d}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("post_reset_out_valid", {63'd0, out_valid}, 64'd0);

    // Back-to-back ops, one cycle latency each
    drive(3'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1);
    check_eq("not_result", {32'd0, reg_d}, 64'h0F0F_EDCB);
    drive(3'd1, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1);
    check_eq("and_result", {32'd0, reg_d}, 64'h00F0_1234);
    drive(3'd6, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1);
    check_eq("xnor_result", {32'd0, reg_d}, 64'h00FF_1234);
    check_eq("xnor_valid", {63'd0, out_valid}, 64'd1);
    idle_cycle();

    // Disabled operation produces zero with normal handshake
    drive(3'd2, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
    check_eq("enable0_reg_d", {32'd0, reg_d}, 64'd0);
    check_eq("enable0_valid", {63'd0, out_valid}, 64'd1);
`ifdef LOGIC_UNIT_FLAGS_EN
    check_eq("enable0_flag_zero", {63'd0, flag_zero}, 64'd1);
    check_eq("enable0_flag_parity", {63'd0, flag_parity}, 64'd0);
`endif
    idle_cycle();
    idle_cycle();

    // Backpressure: two absorbed, third stalls until release
    out_ready = 1'b0;
    drive(3'd7, 32'd1, 32'd0, 1'b1);
    check_eq("bp_ready_after_1", {63'd0, in_ready}, 64'd1);
    drive(3'd7, 32'd2, 32'd0, 1'b1);
    check_eq("bp_ready_after_2", {63'd0, in_ready}, 64'd0);
    check_eq("bp_head_1", {32'd0, reg_d}, 64'd1);
    op = 3'd7; reg_s1 = 32'd3; in_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check_eq("bp_stall_ready", {63'd0, in_ready}, 64'd0);
    check_eq("bp_stall_hold", {32'd0, reg_d}, 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_out_2", {32'd0, reg_d}, 64'd2);
    check_eq("bp_ready_back", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("bp_out_3", {32'd0, reg_d}, 64'd3);
    check_eq("bp_out_3_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    check_eq("bp_drained", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    drive(3'd3, 32'hAAAA_0000, 32'h0000_5555, 1'b1);
    drive(3'd4, 32'h1234_5678, 32'hFFFF_0000, 1'b1);
    in_valid = 1'b0;
    check_eq("full_before_reset", {63'd0, in_ready}, 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("async_rst_reg_d", {32'd0, reg_d}, 64'd0);
    check_eq("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    drive(3'd7, 32'h0000_00A5, 32'd0, 1'b1);
    check_eq("post_rst_first", {32'd0, reg_d}, 64'h0000_00A5);
    check_eq("post_rst_valid", {63'd0, out_valid}, 64'd1);
    idle_cycle();

    // Random stream with random backpressure, checked by the scoreboard
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) idle_cycle();
          drive(3'($urandom_range(0, 7)), $urandom(), $urandom(), ($urandom_range(0, 7) != 0));
        end
        in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
